// File: rtl/aes_pkg.sv
// Shared definitions for the AES CTR-mode stream sequencer.
// Provides block/word geometry and the sequencer state encoding.
package aes_pkg;

   localparam int unsigned KEY_W           = 128;
   localparam int unsigned TEXT_W          = 128;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned WORDS_PER_BLOCK = 4;
   localparam int unsigned IDX_W           = 2;
   localparam int unsigned BLK_CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_READY = 2'd3
   } state_t;

endpackage

// File: rtl/aes_ctr_stream.sv
// CTR-mode sequencer around an external AES-128 cipher core.
// Builds counter blocks, pulses the core's load, captures each result as
// keystream and XORs it onto a 32-bit valid/ready word stream.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cfg_key, cfg_iv, cfg_start  stream configuration, sampled on cfg_start
//   in_valid/in_ready/in_data   input word stream (in_ready combinational)
//   out_valid/out_ready/out_data output word stream (out_valid/out_data combinational)
//   aes_ld, aes_key, aes_text_in to cipher core
//   aes_done, aes_text_out      from cipher core
//   busy                        any state other than idle
//   blocks_done                 fully consumed keystream blocks, wrapping
module aes_ctr_stream
   import aes_pkg::*;
#(
   parameter int unsigned CTR_BITS = 32
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [KEY_W-1:0]     cfg_key,
   input  logic [TEXT_W-1:0]    cfg_iv,
   input  logic                 cfg_start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_W-1:0]    out_data,
   output logic                 aes_ld,
   output logic [KEY_W-1:0]     aes_key,
   output logic [TEXT_W-1:0]    aes_text_in,
   input  logic                 aes_done,
   input  logic [TEXT_W-1:0]    aes_text_out,
   output logic                 busy,
   output logic [BLK_CNT_W-1:0] blocks_done
);

   // Bits of the counter block that increment; the rest stay fixed per stream.
   localparam logic [TEXT_W-1:0] CTR_MASK = {TEXT_W{1'b1}} >> (TEXT_W - CTR_BITS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

   state_t              state;
   state_t              state_nxt;
   logic [TEXT_W-1:0]   keystream;
   logic [IDX_W-1:0]    word_idx;
   logic                discard;

   logic                xfer;
   logic                ks_load;
   logic                ctr_step;
   logic                drop_done;

   // State register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-state strobes; a start request overrides everything.
   always_comb begin
      state_nxt = state;
      aes_ld    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      xfer      = 1'b0;
      ks_load   = 1'b0;
      ctr_step  = 1'b0;
      drop_done = 1'b0;

      case (state)
         ST_IDLE: begin
         end
         ST_LOAD: begin
            aes_ld    = 1'b1;
            ctr_step  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (aes_done) begin
               if (discard) begin
                  drop_done = 1'b1;
                  state_nxt = ST_LOAD;
               end else begin
                  ks_load   = 1'b1;
                  state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            // Handshake is blocked on a start cycle so no word is consumed twice or dropped.
            in_ready  = out_ready & ~cfg_start;
            out_valid = in_valid & ~cfg_start;
            xfer      = in_valid & out_ready & ~cfg_start;
            if (xfer && (word_idx == LAST_IDX)) begin
               state_nxt = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (cfg_start) begin
         state_nxt = ST_LOAD;
      end
   end

   // Datapath registers: key, counter block, keystream, word pointer, counters.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         aes_key     <= '0;
         aes_text_in <= '0;
         keystream   <= '0;
         word_idx    <= '0;
         discard     <= 1'b0;
         blocks_done <= '0;
      end else if (cfg_start) begin
         aes_key     <= cfg_key;
         aes_text_in <= cfg_iv;
         word_idx    <= '0;
         // A core result already in flight belongs to the old stream.
         if (state == ST_WAIT) begin
            discard <= 1'b1;
         end
      end else begin
         if (ctr_step) begin
            aes_text_in <= (aes_text_in & ~CTR_MASK) |
                           ((aes_text_in + TEXT_W'(1)) & CTR_MASK);
         end
         if (drop_done) begin
            discard <= 1'b0;
         end
         if (ks_load) begin
            keystream <= aes_text_out;
            word_idx  <= '0;
         end
         if (xfer) begin
            word_idx <= word_idx + IDX_W'(1);
            if (word_idx == LAST_IDX) begin
               blocks_done <= blocks_done + BLK_CNT_W'(1);
            end
         end
      end
   end

   // Word 0 is the least significant 32 bits of the keystream block.
   always_comb begin
      out_data = in_data ^ keystream[WORD_W*word_idx +: WORD_W];
   end

   assign busy = (state != ST_IDLE);

endmodule
